// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings and the decoded control bundle for the pipeline control unit.
package pipe_ctrl_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OP3   = 6'b011110;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  // ALU codes are always 3 bits; the top widens them to ALUC_W
  localparam int ALU_W = 3;
  localparam logic [ALU_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALU_W-1:0] ALU_SUB = 3'b001;
  localparam logic [ALU_W-1:0] ALU_AND = 3'b010;
  localparam logic [ALU_W-1:0] ALU_OP3 = 3'b011;
  localparam logic [ALU_W-1:0] ALU_OR  = 3'b100;
  localparam logic [ALU_W-1:0] ALU_SLT = 3'b101;

  // Next-PC selection
  localparam logic [1:0] PC_SEQ    = 2'b00;
  localparam logic [1:0] PC_JUMP   = 2'b01;
  localparam logic [1:0] PC_BRANCH = 2'b10;

  // EX operand source selection
  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b10;
  localparam logic [1:0] FWD_MEMWB = 2'b01;

  // Which ID register field names the destination; the top turns it into an
  // address so the decoder stays independent of the register address width.
  typedef enum logic [1:0] {
    DST_NONE = 2'd0,
    DST_RT   = 2'd1,
    DST_RD   = 2'd2
  } dst_src_e;

  typedef struct packed {
    logic [ALU_W-1:0] alu_c;
    logic             alu_src;
    logic             reg_write;
    logic             mem_to_reg;
    logic             mem_write;
    logic             branch_eq;
    logic             branch_ne;
    logic             jump;
    dst_src_e         dst;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    alu_c:      ALU_ADD,
    alu_src:    1'b0,
    reg_write:  1'b0,
    mem_to_reg: 1'b0,
    mem_write:  1'b0,
    branch_eq:  1'b0,
    branch_ne:  1'b0,
    jump:       1'b0,
    dst:        DST_NONE
  };

endpackage

// File: rtl/pipe_ctrl_decode.sv
// Combinational ID-stage decoder: opcode/funct to control bundle and source usage.
module pipe_ctrl_decode
  import pipe_ctrl_pkg::*;
#(
  parameter int EXT_OPS = 1
) (
  input  logic [5:0] op,
  input  logic [5:0] funct,
  output ctrl_t      ctrl,
  output logic       uses_rs,
  output logic       uses_rt
);

  logic             r_ok;
  logic [ALU_W-1:0] r_alu;

  // Map R-type funct to an ALU code; unknown funct makes the instruction a NOP
  always_comb begin
    r_ok  = 1'b1;
    r_alu = ALU_ADD;
    case (funct)
      FN_ADD:  r_alu = ALU_ADD;
      FN_SUB:  r_alu = ALU_SUB;
      FN_AND:  r_alu = ALU_AND;
      FN_OP3:  r_alu = ALU_OP3;
      FN_OR:   r_alu = ALU_OR;
      FN_SLT:  r_alu = ALU_SLT;
      default: r_ok  = 1'b0;
    endcase
  end

  // Opcode decode; anything unrecognised leaves the NOP defaults in place
  always_comb begin
    ctrl    = CTRL_NOP;
    uses_rs = 1'b0;
    uses_rt = 1'b0;
    case (op)
      OP_RTYPE: begin
        if (r_ok) begin
          ctrl.alu_c     = r_alu;
          ctrl.reg_write = 1'b1;
          ctrl.dst       = DST_RD;
          uses_rs        = 1'b1;
          uses_rt        = 1'b1;
        end
      end
      OP_ADDI: begin
        ctrl.alu_c     = ALU_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.dst       = DST_RT;
        uses_rs        = 1'b1;
      end
      OP_LW: begin
        ctrl.alu_c      = ALU_ADD;
        ctrl.alu_src    = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        ctrl.dst        = DST_RT;
        uses_rs         = 1'b1;
      end
      OP_SW: begin
        ctrl.alu_c     = ALU_ADD;
        ctrl.alu_src   = 1'b1;
        ctrl.mem_write = 1'b1;
        uses_rs        = 1'b1;
        uses_rt        = 1'b1;
      end
      OP_BEQ: begin
        ctrl.alu_c     = ALU_SUB;
        ctrl.branch_eq = 1'b1;
        uses_rs        = 1'b1;
        uses_rt        = 1'b1;
      end
      OP_BNE: begin
        if (EXT_OPS != 0) begin
          ctrl.alu_c     = ALU_SUB;
          ctrl.branch_ne = 1'b1;
          uses_rs        = 1'b1;
          uses_rt        = 1'b1;
        end
      end
      OP_ORI: begin
        if (EXT_OPS != 0) begin
          ctrl.alu_c     = ALU_OR;
          ctrl.alu_src   = 1'b1;
          ctrl.reg_write = 1'b1;
          ctrl.dst       = DST_RT;
          uses_rs        = 1'b1;
        end
      end
      OP_J: begin
        ctrl.jump = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pipe_ctrl_unit.sv
// Pipeline control and hazard unit: decode, ID/EX..MEM/WB control stages,
// load-use / RAW stalls, forwarding selects and branch/jump redirection.
module pipe_ctrl_unit
  import pipe_ctrl_pkg::*;
#(
  parameter int REG_AW  = 5,
  parameter int ALUC_W  = 3,
  parameter int FWD_EN  = 1,
  parameter int EXT_OPS = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [5:0]        id_op,
  input  logic [5:0]        id_funct,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              ex_zero,
  output logic              pc_write,
  output logic              ifid_write,
  output logic              ifid_flush,
  output logic [1:0]        pc_sel,
  output logic [ALUC_W-1:0] ex_alu_c,
  output logic              ex_alu_src,
  output logic              ex_reg_write,
  output logic              ex_mem_to_reg,
  output logic              ex_mem_write,
  output logic [REG_AW-1:0] ex_rs,
  output logic [REG_AW-1:0] ex_rt,
  output logic [REG_AW-1:0] ex_dst,
  output logic              mem_reg_write,
  output logic              mem_mem_to_reg,
  output logic              mem_mem_write,
  output logic [REG_AW-1:0] mem_dst,
  output logic              wb_reg_write,
  output logic              wb_mem_to_reg,
  output logic [REG_AW-1:0] wb_dst,
  output logic [1:0]        fwd_a,
  output logic [1:0]        fwd_b
);

  // ---------------------------------------------------------------- decode
  ctrl_t             id_ctrl;
  logic              id_uses_rs;
  logic              id_uses_rt;
  logic [REG_AW-1:0] id_dst;
  logic              id_reg_write;

  pipe_ctrl_decode #(
    .EXT_OPS (EXT_OPS)
  ) u_decode (
    .op      (id_op),
    .funct   (id_funct),
    .ctrl    (id_ctrl),
    .uses_rs (id_uses_rs),
    .uses_rt (id_uses_rt)
  );

  // Resolve the destination field; writes to $0 are dropped at the source
  always_comb begin
    id_dst = '0;
    case (id_ctrl.dst)
      DST_RT:  id_dst = id_rt;
      DST_RD:  id_dst = id_rd;
      default: id_dst = '0;
    endcase
    id_reg_write = id_ctrl.reg_write & (id_dst != '0);
  end

  // ---------------------------------------------------------- stage state
  logic [ALU_W-1:0]  ex_alu_c_reg;
  logic              ex_alu_src_reg;
  logic              ex_reg_write_reg;
  logic              ex_mem_to_reg_reg;
  logic              ex_mem_write_reg;
  logic              ex_branch_eq_reg;
  logic              ex_branch_ne_reg;
  logic [REG_AW-1:0] ex_rs_reg;
  logic [REG_AW-1:0] ex_rt_reg;
  logic [REG_AW-1:0] ex_dst_reg;

  logic              mem_reg_write_reg;
  logic              mem_mem_to_reg_reg;
  logic              mem_mem_write_reg;
  logic [REG_AW-1:0] mem_dst_reg;

  logic              wb_reg_write_reg;
  logic              wb_mem_to_reg_reg;
  logic [REG_AW-1:0] wb_dst_reg;

  // ------------------------------------------------------- hazard / redirect
  logic stall_raw;
  logic branch_taken;
  logic hazard;
  logic do_jump;
  logic id_ex_bubble;

  // True when a live producer writing dst feeds a source the ID instruction reads
  function automatic logic feeds_id(input logic wr, input logic [REG_AW-1:0] dst,
                                    input logic use_rs, input logic [REG_AW-1:0] rs,
                                    input logic use_rt, input logic [REG_AW-1:0] rt);
    return wr && (dst != '0) && ((use_rs && dst == rs) || (use_rt && dst == rt));
  endfunction

  // With forwarding only a load in EX must stall; without it every in-flight
  // writer in EX or MEM must drain (WB is covered by write-before-read)
  always_comb begin
    stall_raw = 1'b0;
    if (FWD_EN != 0) begin
      stall_raw = feeds_id(ex_mem_to_reg_reg, ex_dst_reg,
                           id_uses_rs, id_rs, id_uses_rt, id_rt);
    end else begin
      stall_raw = feeds_id(ex_reg_write_reg, ex_dst_reg,
                           id_uses_rs, id_rs, id_uses_rt, id_rt)
                | feeds_id(mem_reg_write_reg, mem_dst_reg,
                           id_uses_rs, id_rs, id_uses_rt, id_rt);
    end
  end

  // Redirect priority: taken branch beats stall, stall holds a pending jump
  always_comb begin
    branch_taken = (ex_branch_eq_reg & ex_zero) | (ex_branch_ne_reg & ~ex_zero);
    hazard       = stall_raw & ~branch_taken;
    do_jump      = id_ctrl.jump & ~hazard & ~branch_taken;
    id_ex_bubble = hazard | branch_taken;
    pc_write     = ~hazard;
    ifid_write   = ~hazard;
    ifid_flush   = branch_taken | do_jump;
    if (branch_taken) begin
      pc_sel = PC_BRANCH;
    end else if (do_jump) begin
      pc_sel = PC_JUMP;
    end else begin
      pc_sel = PC_SEQ;
    end
  end

  // ID/EX: loads the decoded instruction, or a NOP bubble on stall / taken branch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_alu_c_reg      <= '0;
      ex_alu_src_reg    <= 1'b0;
      ex_reg_write_reg  <= 1'b0;
      ex_mem_to_reg_reg <= 1'b0;
      ex_mem_write_reg  <= 1'b0;
      ex_branch_eq_reg  <= 1'b0;
      ex_branch_ne_reg  <= 1'b0;
      ex_rs_reg         <= '0;
      ex_rt_reg         <= '0;
      ex_dst_reg        <= '0;
    end else if (id_ex_bubble) begin
      ex_alu_c_reg      <= '0;
      ex_alu_src_reg    <= 1'b0;
      ex_reg_write_reg  <= 1'b0;
      ex_mem_to_reg_reg <= 1'b0;
      ex_mem_write_reg  <= 1'b0;
      ex_branch_eq_reg  <= 1'b0;
      ex_branch_ne_reg  <= 1'b0;
      ex_rs_reg         <= '0;
      ex_rt_reg         <= '0;
      ex_dst_reg        <= '0;
    end else begin
      ex_alu_c_reg      <= id_ctrl.alu_c;
      ex_alu_src_reg    <= id_ctrl.alu_src;
      ex_reg_write_reg  <= id_reg_write;
      ex_mem_to_reg_reg <= id_ctrl.mem_to_reg;
      ex_mem_write_reg  <= id_ctrl.mem_write;
      ex_branch_eq_reg  <= id_ctrl.branch_eq;
      ex_branch_ne_reg  <= id_ctrl.branch_ne;
      ex_rs_reg         <= id_rs;
      ex_rt_reg         <= id_rt;
      ex_dst_reg        <= id_dst;
    end
  end

  // EX/MEM and MEM/WB: free-running shift of the remaining controls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_reg_write_reg  <= 1'b0;
      mem_mem_to_reg_reg <= 1'b0;
      mem_mem_write_reg  <= 1'b0;
      mem_dst_reg        <= '0;
      wb_reg_write_reg   <= 1'b0;
      wb_mem_to_reg_reg  <= 1'b0;
      wb_dst_reg         <= '0;
    end else begin
      mem_reg_write_reg  <= ex_reg_write_reg;
      mem_mem_to_reg_reg <= ex_mem_to_reg_reg;
      mem_mem_write_reg  <= ex_mem_write_reg;
      mem_dst_reg        <= ex_dst_reg;
      wb_reg_write_reg   <= mem_reg_write_reg;
      wb_mem_to_reg_reg  <= mem_mem_to_reg_reg;
      wb_dst_reg         <= mem_dst_reg;
    end
  end

  // ----------------------------------------------------------- forwarding
  function automatic logic [1:0] fwd_for(input logic [REG_AW-1:0] src,
                                         input logic mem_wr, input logic [REG_AW-1:0] mem_d,
                                         input logic wb_wr, input logic [REG_AW-1:0] wb_d);
    if (mem_wr && mem_d != '0 && mem_d == src) begin
      return FWD_EXMEM;
    end else if (wb_wr && wb_d != '0 && wb_d == src) begin
      return FWD_MEMWB;
    end
    return FWD_RF;
  endfunction

  // Operand selects for EX; the younger EX/MEM result wins over MEM/WB
  always_comb begin
    fwd_a = FWD_RF;
    fwd_b = FWD_RF;
    if (FWD_EN != 0) begin
      fwd_a = fwd_for(ex_rs_reg, mem_reg_write_reg, mem_dst_reg,
                      wb_reg_write_reg, wb_dst_reg);
      fwd_b = fwd_for(ex_rt_reg, mem_reg_write_reg, mem_dst_reg,
                      wb_reg_write_reg, wb_dst_reg);
    end
  end

  // -------------------------------------------------------------- outputs
  assign ex_alu_c       = ALUC_W'(ex_alu_c_reg);
  assign ex_alu_src     = ex_alu_src_reg;
  assign ex_reg_write   = ex_reg_write_reg;
  assign ex_mem_to_reg  = ex_mem_to_reg_reg;
  assign ex_mem_write   = ex_mem_write_reg;
  assign ex_rs          = ex_rs_reg;
  assign ex_rt          = ex_rt_reg;
  assign ex_dst         = ex_dst_reg;
  assign mem_reg_write  = mem_reg_write_reg;
  assign mem_mem_to_reg = mem_mem_to_reg_reg;
  assign mem_mem_write  = mem_mem_write_reg;
  assign mem_dst        = mem_dst_reg;
  assign wb_reg_write   = wb_reg_write_reg;
  assign wb_mem_to_reg  = wb_mem_to_reg_reg;
  assign wb_dst         = wb_dst_reg;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// Directed bench: instance a (forwarding, extended ops) and instance b
// (no forwarding, base ops only) share one ID instruction stream.
module tb_pipe_ctrl_unit;

  typedef struct {
    logic       pc_write, ifid_write, ifid_flush;
    logic [1:0] pc_sel;
    logic [2:0] ex_alu_c;
    logic       ex_alu_src, ex_reg_write, ex_mem_to_reg, ex_mem_write;
    logic [4:0] ex_rs, ex_rt, ex_dst;
    logic       mem_reg_write, mem_mem_to_reg, mem_mem_write;
    logic [4:0] mem_dst;
    logic       wb_reg_write, wb_mem_to_reg;
    logic [4:0] wb_dst;
    logic [1:0] fwd_a, fwd_b;
  } outs_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] id_op, id_funct;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       ex_zero;
  outs_t      a, b;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pipe_ctrl_unit #(.REG_AW(5), .ALUC_W(3), .FWD_EN(1), .EXT_OPS(1)) dut_a (
    .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
    .pc_write(a.pc_write), .ifid_write(a.ifid_write), .ifid_flush(a.ifid_flush),
    .pc_sel(a.pc_sel), .ex_alu_c(a.ex_alu_c), .ex_alu_src(a.ex_alu_src),
    .ex_reg_write(a.ex_reg_write), .ex_mem_to_reg(a.ex_mem_to_reg),
    .ex_mem_write(a.ex_mem_write), .ex_rs(a.ex_rs), .ex_rt(a.ex_rt), .ex_dst(a.ex_dst),
    .mem_reg_write(a.mem_reg_write), .mem_mem_to_reg(a.mem_mem_to_reg),
    .mem_mem_write(a.mem_mem_write), .mem_dst(a.mem_dst),
    .wb_reg_write(a.wb_reg_write), .wb_mem_to_reg(a.wb_mem_to_reg), .wb_dst(a.wb_dst),
    .fwd_a(a.fwd_a), .fwd_b(a.fwd_b)
  );

  pipe_ctrl_unit #(.REG_AW(5), .ALUC_W(3), .FWD_EN(0), .EXT_OPS(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .id_op(id_op), .id_funct(id_funct),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_zero(ex_zero),
    .pc_write(b.pc_write), .ifid_write(b.ifid_write), .ifid_flush(b.ifid_flush),
    .pc_sel(b.pc_sel), .ex_alu_c(b.ex_alu_c), .ex_alu_src(b.ex_alu_src),
    .ex_reg_write(b.ex_reg_write), .ex_mem_to_reg(b.ex_mem_to_reg),
    .ex_mem_write(b.ex_mem_write), .ex_rs(b.ex_rs), .ex_rt(b.ex_rt), .ex_dst(b.ex_dst),
    .mem_reg_write(b.mem_reg_write), .mem_mem_to_reg(b.mem_mem_to_reg),
    .mem_mem_write(b.mem_mem_write), .mem_dst(b.mem_dst),
    .wb_reg_write(b.wb_reg_write), .wb_mem_to_reg(b.wb_mem_to_reg), .wb_dst(b.wb_dst),
    .fwd_a(b.fwd_a), .fwd_b(b.fwd_b)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic rtype(input logic [5:0] fn, input logic [4:0] rs, rt, rd);
    id_op = 6'b000000; id_funct = fn; id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  task automatic itype(input logic [5:0] op, input logic [4:0] rs, rt);
    id_op = op; id_funct = 6'b000000; id_rs = rs; id_rt = rt; id_rd = 5'd0;
  endtask

  task automatic nop();
    rtype(6'b000000, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; ex_zero = 1'b0; nop();
    tick(); tick();
    chk("rst_ex_reg_write", a.ex_reg_write, 0);
    chk("rst_ex_dst", a.ex_dst, 0);
    chk("rst_wb_reg_write", a.wb_reg_write, 0);
    chk("rst_pc_write", a.pc_write, 1);
    chk("rst_ifid_write", a.ifid_write, 1);
    chk("rst_ifid_flush", a.ifid_flush, 0);
    chk("rst_pc_sel", a.pc_sel, 0);
    chk("rst_fwd_a", a.fwd_a, 0);
    rst_n = 1'b1;

    // add $3,$1,$2 followed by sub $6,$3,$3
    rtype(6'b100000, 5'd1, 5'd2, 5'd3); tick();
    $display("[TB] add $3,$1,$2 in EX");
    chk("add_ex_alu_c", a.ex_alu_c, 0);
    chk("add_ex_reg_write", a.ex_reg_write, 1);
    chk("add_ex_dst", a.ex_dst, 3);
    chk("add_ex_rs", a.ex_rs, 1);
    chk("add_ex_rt", a.ex_rt, 2);
    rtype(6'b100010, 5'd3, 5'd3, 5'd6); #1;
    $display("[TB] sub $6,$3,$3 in ID");
    chk("raw_a_pc_write", a.pc_write, 1);
    chk("raw_b_pc_write", b.pc_write, 0);
    chk("raw_b_ifid_write", b.ifid_write, 0);
    tick();
    chk("raw_a_ex_alu_c", a.ex_alu_c, 1);
    chk("raw_a_fwd_a", a.fwd_a, 2);
    chk("raw_a_fwd_b", a.fwd_b, 2);
    chk("raw_a_mem_dst", a.mem_dst, 3);
    chk("raw_b_bubble", b.ex_reg_write, 0);
    chk("raw_b_stall2", b.pc_write, 0);
    tick();
    chk("add_wb_reg_write", a.wb_reg_write, 1);
    chk("add_wb_dst", a.wb_dst, 3);
    chk("raw_a_fwd_memwb", a.fwd_a, 1);
    chk("raw_b_release", b.pc_write, 1);
    tick();
    chk("raw_b_ex_alu_c", b.ex_alu_c, 1);
    chk("raw_b_ex_dst", b.ex_dst, 6);
    chk("raw_b_fwd_a", b.fwd_a, 0);
    chk("raw_b_fwd_b", b.fwd_b, 0);
    nop(); tick(); tick(); tick();

    // lw $4,0($1) then add $5,$4,$2
    itype(6'b100011, 5'd1, 5'd4); tick();
    $display("[TB] lw $4,0($1) in EX");
    chk("lw_ex_mem_to_reg", a.ex_mem_to_reg, 1);
    chk("lw_ex_alu_src", a.ex_alu_src, 1);
    chk("lw_ex_dst", a.ex_dst, 4);
    rtype(6'b100000, 5'd4, 5'd2, 5'd5); #1;
    chk("lu_pc_write", a.pc_write, 0);
    chk("lu_ifid_write", a.ifid_write, 0);
    tick();
    chk("lu_bubble_rw", a.ex_reg_write, 0);
    chk("lu_bubble_dst", a.ex_dst, 0);
    chk("lu_release", a.pc_write, 1);
    tick();
    $display("[TB] add $5,$4,$2 in EX after load-use stall");
    chk("lu_ex_dst", a.ex_dst, 5);
    chk("lu_fwd_a", a.fwd_a, 1);
    chk("lu_fwd_b", a.fwd_b, 0);
    nop(); tick(); tick(); tick();

    // beq taken in EX with j in ID
    itype(6'b000100, 5'd1, 5'd2); tick();
    chk("beq_ex_alu_c", a.ex_alu_c, 1);
    itype(6'b000010, 5'd0, 5'd0); ex_zero = 1'b1; #1;
    $display("[TB] beq taken, j in ID");
    chk("beq_pc_sel", a.pc_sel, 2);
    chk("beq_ifid_flush", a.ifid_flush, 1);
    chk("beq_pc_write", a.pc_write, 1);
    chk("beq_b_pc_sel", b.pc_sel, 2);
    tick(); ex_zero = 1'b0; #1;
    chk("j_pc_sel", a.pc_sel, 1);
    chk("j_ifid_flush", a.ifid_flush, 1);
    // beq taken with a real instruction in ID: it must become a bubble
    itype(6'b000100, 5'd1, 5'd2); tick();
    rtype(6'b100000, 5'd1, 5'd2, 5'd3); ex_zero = 1'b1; #1;
    chk("beq2_pc_sel", a.pc_sel, 2);
    tick(); ex_zero = 1'b0;
    chk("beq2_bubble_rw", a.ex_reg_write, 0);
    chk("beq2_bubble_dst", a.ex_dst, 0);
    nop(); tick();

    // bne / ori: extended ops only in instance a
    itype(6'b000101, 5'd1, 5'd2); tick();
    nop(); #1;
    $display("[TB] bne in EX, ex_zero=0");
    chk("bne_a_pc_sel", a.pc_sel, 2);
    chk("bne_b_pc_sel", b.pc_sel, 0);
    chk("bne_a_alu_c", a.ex_alu_c, 1);
    chk("bne_b_alu_c", b.ex_alu_c, 0);
    itype(6'b001101, 5'd1, 5'd7); ex_zero = 1'b1; #1;
    chk("bne_nt_pc_sel", a.pc_sel, 0);
    tick(); ex_zero = 1'b0;
    $display("[TB] ori $7,$1 in EX");
    chk("ori_alu_c", a.ex_alu_c, 4);
    chk("ori_alu_src", a.ex_alu_src, 1);
    chk("ori_reg_write", a.ex_reg_write, 1);
    chk("ori_dst", a.ex_dst, 7);
    chk("ori_b_reg_write", b.ex_reg_write, 0);
    chk("ori_b_alu_src", b.ex_alu_src, 0);

    // addi $0,$1,5 then a consumer of $0
    itype(6'b001000, 5'd1, 5'd0); tick();
    $display("[TB] addi $0,$1,5 in EX");
    chk("addi0_reg_write", a.ex_reg_write, 0);
    chk("addi0_alu_src", a.ex_alu_src, 1);
    rtype(6'b100000, 5'd0, 5'd2, 5'd8); #1;
    chk("zero_a_no_stall", a.pc_write, 1);
    chk("zero_b_no_stall", b.pc_write, 1);
    tick();
    chk("zero_fwd_a", a.fwd_a, 0);
    chk("zero_ex_dst", a.ex_dst, 8);

    // Remaining funct codes and an unknown opcode
    rtype(6'b101010, 5'd1, 5'd2, 5'd10); tick();
    chk("slt_alu_c", a.ex_alu_c, 5);
    rtype(6'b011110, 5'd1, 5'd2, 5'd11); tick();
    chk("op3_alu_c", a.ex_alu_c, 3);
    itype(6'b111111, 5'd1, 5'd2); tick();
    chk("unk_reg_write", a.ex_reg_write, 0);
    chk("unk_alu_c", a.ex_alu_c, 0);

    // Asynchronous reset in the middle of traffic
    rtype(6'b100000, 5'd1, 5'd2, 5'd9); tick();
    rtype(6'b100000, 5'd1, 5'd2, 5'd12); tick();
    chk("pre_rst_mem_dst", a.mem_dst, 9);
    #2 rst_n = 1'b0; #1;
    $display("[TB] rst_n low mid-stream");
    chk("mrst_ex_reg_write", a.ex_reg_write, 0);
    chk("mrst_ex_dst", a.ex_dst, 0);
    chk("mrst_mem_reg_write", a.mem_reg_write, 0);
    chk("mrst_mem_dst", a.mem_dst, 0);
    chk("mrst_wb_dst", a.wb_dst, 0);
    rst_n = 1'b1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
